// File: rtl/fir_pkg.sv
`default_nettype none
// fir_pkg: width helpers and the round-half-up saturating output function shared by the FIR. Rev 1.0
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic int lat(input int taps);
    return 2 + clog2(taps);
  endfunction

  // Valid for accumulators narrower than 63 bits; rounds half up before the shift.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_stream_param_adder_tree.sv
`default_nettype none
// fir_adder_tree: pipelined, enable-gated binary adder tree with clog2(N) registered levels
// and a valid bit riding alongside; an odd node at any level is paired with zero. Rev 1.0
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int N    = 16,
  parameter int IN_W = 32,
  localparam int LVLS  = clog2(N),
  localparam int SUM_W = IN_W + LVLS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic signed [IN_W-1:0]  data_i [N],
  output logic                    vld_o,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [SUM_W-1:0] ext [N];

  for (genvar k = 0; k < N; k++) begin : g_ext
    assign ext[k] = {{LVLS{data_i[k][IN_W-1]}}, data_i[k]};
  end

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int NP = (N + (1 << (l - 1)) - 1) >> (l - 1);
    localparam int NC = (NP + 1) / 2;

    logic vld_d;
    logic vld_q;

    if (l == 1) begin : g_vsrc
      assign vld_d = vld_i;
    end else begin : g_vsrc
      assign vld_d = g_lvl[l-1].vld_q;
    end

    always_ff @(posedge clk) begin
      if (!reset)    vld_q <= 1'b0;
      else if (en_i) vld_q <= vld_d;
    end

    for (genvar j = 0; j < NC; j++) begin : g_node
      logic signed [SUM_W-1:0] lhs;
      logic signed [SUM_W-1:0] rhs;
      logic signed [SUM_W-1:0] sum_q;

      if (l == 1) begin : g_src
        assign lhs = ext[2*j];
        if (2*j + 1 < NP) begin : g_pair
          assign rhs = ext[2*j+1];
        end else begin : g_pad
          assign rhs = '0;
        end
      end else begin : g_src
        assign lhs = g_lvl[l-1].g_node[2*j].sum_q;
        if (2*j + 1 < NP) begin : g_pair
          assign rhs = g_lvl[l-1].g_node[2*j+1].sum_q;
        end else begin : g_pad
          assign rhs = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset)    sum_q <= '0;
        else if (en_i) sum_q <= lhs + rhs;
      end
    end
  end

  assign vld_o = g_lvl[LVLS].vld_q;
  assign sum_o = g_lvl[LVLS].g_node[0].sum_q;

endmodule
`default_nettype wire

// File: rtl/fir_stream_param.sv
`default_nettype none
// fir_stream_param: streaming pipelined FIR with back-pressure and double-buffered coefficients.
// Define FIR_SAT_EN for a round-half-up saturating output; otherwise the output wraps. Rev 1.0
module fir_stream_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0,
  localparam int AW = clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_swap
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

  logic                     en;
  logic                     accept;
  logic signed [DATA_W-1:0] x_q     [TAPS];
  logic signed [COEF_W-1:0] h_act_q [TAPS];
  logic signed [COEF_W-1:0] h_shd_q [TAPS];
  logic signed [PROD_W-1:0] prod_q  [TAPS];
  logic                     x_vld_q;
  logic                     prod_vld_q;
  logic                     acc_vld;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  out_data_d;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]     <= '0;
        h_act_q[k] <= '0;
        h_shd_q[k] <= '0;
        prod_q[k]  <= '0;
      end
      x_vld_q    <= 1'b0;
      prod_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (en) begin
        x_vld_q    <= accept;
        prod_vld_q <= x_vld_q;
        for (int k = 0; k < TAPS; k++) prod_q[k] <= x_q[k] * h_act_q[k];
      end
      if (coef_we && (32'(coef_addr) < TAPS)) h_shd_q[coef_addr] <= coef_data;
      // Reads the shadow bank as it was before this edge's write.
      if (coef_swap) begin
        for (int k = 0; k < TAPS; k++) h_act_q[k] <= h_shd_q[k];
      end
    end
  end

  fir_adder_tree #(
    .N    (TAPS),
    .IN_W (PROD_W)
  ) u_tree (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en),
    .vld_i  (prod_vld_q),
    .data_i (prod_q),
    .vld_o  (acc_vld),
    .sum_o  (acc)
  );

`ifdef FIR_SAT_EN
  assign out_data_d = OUT_W'(sat_round(64'(acc), SHIFT, OUT_W));
`else
  assign out_data_d = OUT_W'(acc >>> SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= acc_vld;
      if (acc_vld) out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_param.sv
`default_nettype none
// tb_fir_stream_param: directed and random streaming checks against an arithmetic FIR model.
module tb_fir_stream_param;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 16;
  localparam int OUT_W  = 32;
  localparam int SHIFT  = 0;
  localparam int LAT    = 6;
`ifdef FIR_SAT_EN
  localparam longint EXP_BIG = -(longint'(1) << 31);
`else
  localparam longint EXP_BIG = 524288;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we = 1'b0;
  logic [3:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     coef_swap = 1'b0;

  always #5 clk = ~clk;

  fir_stream_param dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_swap (coef_swap)
  );

  int checks = 0;
  int failures = 0;

  longint hist [TAPS];
  longint act  [TAPS];
  longint shd  [TAPS];
  longint expq [$];
  logic   held_pending = 1'b0;
  logic signed [OUT_W-1:0] held_val = '0;
  logic signed [OUT_W-1:0] last_dut = '0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint xform(input longint acc);
    longint r;
`ifdef FIR_SAT_EN
    r = (acc + ((SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : longint'(0))) >>> SHIFT;
    if (r > (longint'(1) << 31) - 1) r = (longint'(1) << 31) - 1;
    else if (r < -(longint'(1) << 31)) r = -(longint'(1) << 31);
`else
    r = acc >>> SHIFT;
    r = longint'(int'(r));
`endif
    return r;
  endfunction

  // One clock: drive at negedge, check/consume outputs, advance the model, wait for posedge.
  task automatic step(input logic v, input logic signed [DATA_W-1:0] d, input logic rdy,
                      input logic we = 1'b0, input logic [3:0] a = '0,
                      input logic signed [COEF_W-1:0] cd = '0, input logic sw = 1'b0);
    longint acc;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy;
    coef_we = we; coef_addr = a; coef_data = cd; coef_swap = sw;
    #1;
    if (held_pending) begin
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", out_data, held_val);
    end
    if (rdy) chk("in_ready_open", in_ready, 1);
    else if (out_valid) chk("in_ready_stall", in_ready, 0);
    held_pending = out_valid && !rdy;
    held_val = out_data;
    if (out_valid && rdy) begin
      if (expq.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        last_dut = out_data;
        chk("out_data", out_data, expq.pop_front());
      end
    end
    if (sw) for (int k = 0; k < TAPS; k++) act[k] = shd[k];
    if (we) shd[a] = cd;
    if (v && in_ready) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += hist[k] * act[k];
      expq.push_back(xform(acc));
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < TAPS; k++) begin hist[k] = 0; act[k] = 0; shd[k] = 0; end
    expq.delete();
    held_pending = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic drain();
    repeat (16) step(1'b0, '0, 1'b1);
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    int  n;
    logic r_sw;
    logic r_rdy;

    do_reset();

    // Impulse response with h = 1..16 and first-output latency.
    for (int k = 0; k < TAPS; k++) step(1'b0, '0, 1'b1, 1'b1, 4'(k), 16'(k + 1));
    step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    step(1'b1, 16'sd1, 1'b1);
    n = 0;
    while (n < 20) begin
      step(1'b1, '0, 1'b1);
      n++;
      #1;
      if (out_valid) break;
    end
    chk("latency", n, LAT);
    repeat (16) step(1'b1, '0, 1'b1);
    drain();

    // Constant input: steady state is 100 * (1+..+16).
    repeat (20) step(1'b1, 16'sd100, 1'b1);
    drain();
    chk("steady_state", last_dut, 13600);

    // Back-pressure in the middle of an impulse.
    step(1'b1, 16'sd1, 1'b1);
    repeat (7) step(1'b1, '0, 1'b1);
    repeat (5) step(1'b1, '0, 1'b0);
    repeat (12) step(1'b1, '0, 1'b1);
    drain();

    // Coefficient swap to all-2 while an impulse is in flight.
    for (int k = 0; k < TAPS; k++) step(1'b1, '0, 1'b1, 1'b1, 4'(k), 16'sd2);
    step(1'b1, 16'sd1, 1'b1);
    repeat (3) step(1'b1, '0, 1'b1);
    step(1'b1, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    repeat (14) step(1'b1, '0, 1'b1);
    step(1'b1, 16'sd1, 1'b1);
    repeat (16) step(1'b1, '0, 1'b1);
    drain();

    // Extreme accumulator: saturates or wraps depending on the build.
    for (int k = 0; k < TAPS; k++) step(1'b0, '0, 1'b1, 1'b1, 4'(k), 16'sh7fff);
    step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    repeat (16) step(1'b1, 16'sh8000, 1'b1);
    drain();
    chk("extreme_acc", last_dut, EXP_BIG);

    // Reset mid-stream: nothing in flight survives and the banks are cleared.
    repeat (8) step(1'b1, 16'($urandom), 1'b1);
    do_reset();
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, 16'sd1, 1'b1);
    repeat (16) step(1'b1, '0, 1'b1);
    drain();

    // Random traffic, coefficient writes, swaps (swaps only with downstream ready).
    for (int i = 0; i < 500; i++) begin
      r_sw  = ($urandom_range(0, 15) == 0);
      r_rdy = r_sw || ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, 16'($urandom), r_rdy,
           $urandom_range(0, 3) == 0, 4'($urandom), 16'($urandom), r_sw);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
